// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: widths, FSM states and FIFO entry.
package ifu_pkg;

    localparam int unsigned INS_LEN = 54;
    localparam int unsigned ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic [INS_LEN-1:0] ins;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of PC-tagged instructions; push and pop may
// coincide at any occupancy, including full. The head reads as zero when empty.
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: walks the PC through the I-cache read port and
// streams PC-tagged words to the decoder through a small prefetch FIFO.
module instruction_fetch_unit #(
    parameter int unsigned INS_LEN    = ifu_pkg::INS_LEN,
    parameter int unsigned ADDR_W     = ifu_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W:0]    ins_count,
    input  logic               flush,
    output logic               icache_rd_ctrl_en,
    output logic [ADDR_W-1:0]  icache_rd_ctrl_addr,
    input  logic [INS_LEN-1:0] icache_rd_ctrl_data,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INS_LEN-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_pc,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_pkg::fetch_state_e state, state_nxt;
    ifu_pkg::fetch_entry_t push_entry, head;

    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W:0]   remaining, remaining_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              issue;

    // A read is only issued when its word can land in the FIFO this cycle,
    // either into a free slot or into the slot freed by a concurrent pop.
    always_comb begin
        pop   = ins_valid && ins_ready;
        issue = rst && !flush && (state == ifu_pkg::FETCH) && (!fifo_full || pop);

        icache_rd_ctrl_en   = issue;
        icache_rd_ctrl_addr = issue ? pc : '0;

        push_entry.ins = icache_rd_ctrl_data;
        push_entry.pc  = pc;

        ins_valid = !fifo_empty;
        ins_data  = head.ins;
        ins_pc    = head.pc;
        busy      = (state != ifu_pkg::IDLE);
        done      = (state == ifu_pkg::DONE);
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        remaining_nxt = remaining;
        case (state)
            ifu_pkg::IDLE: begin
                if (start) begin
                    if (ins_count != '0) begin
                        state_nxt     = ifu_pkg::FETCH;
                        pc_nxt        = start_addr;
                        remaining_nxt = ins_count;
                    end else begin
                        state_nxt = ifu_pkg::DONE;
                    end
                end
            end
            ifu_pkg::FETCH: begin
                if (issue) begin
                    pc_nxt        = pc + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state_nxt = ifu_pkg::DRAIN;
                    end
                end
            end
            ifu_pkg::DRAIN: begin
                if (pop && fifo_count == CNT_W'(1)) begin
                    state_nxt = ifu_pkg::DONE;
                end
            end
            ifu_pkg::DONE: begin
                state_nxt = ifu_pkg::IDLE;
            end
            default: begin
                state_nxt = ifu_pkg::IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = ifu_pkg::IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ifu_pkg::IDLE;
            pc        <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            remaining <= remaining_nxt;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (pop),
        .clear (flush),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a combinational
// I-cache model whose word is derived from the read address.
module tb_instruction_fetch_unit;

    localparam int unsigned INS_LEN = 54;
    localparam int unsigned ADDR_W  = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W:0]    ins_count;
    logic               flush;
    logic               icache_rd_ctrl_en;
    logic [ADDR_W-1:0]  icache_rd_ctrl_addr;
    logic [INS_LEN-1:0] icache_rd_ctrl_data;
    logic               ins_valid;
    logic               ins_ready;
    logic [INS_LEN-1:0] ins_data;
    logic [ADDR_W-1:0]  ins_pc;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [INS_LEN-1:0] cache_word(input logic [ADDR_W-1:0] a);
        return {a, a, a, a, a, 4'h5};
    endfunction

    assign icache_rd_ctrl_data = cache_word(icache_rd_ctrl_addr);

    instruction_fetch_unit #(
        .INS_LEN    (INS_LEN),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .start_addr          (start_addr),
        .ins_count           (ins_count),
        .flush               (flush),
        .icache_rd_ctrl_en   (icache_rd_ctrl_en),
        .icache_rd_ctrl_addr (icache_rd_ctrl_addr),
        .icache_rd_ctrl_data (icache_rd_ctrl_data),
        .ins_valid           (ins_valid),
        .ins_ready           (ins_ready),
        .ins_data            (ins_data),
        .ins_pc              (ins_pc),
        .busy                (busy),
        .done                (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    64'(icache_rd_ctrl_en),   64'd0);
        check({tag, "_addr"},  64'(icache_rd_ctrl_addr), 64'd0);
        check({tag, "_valid"}, 64'(ins_valid),           64'd0);
        check({tag, "_data"},  64'(ins_data),            64'd0);
        check({tag, "_pc"},    64'(ins_pc),              64'd0);
        check({tag, "_busy"},  64'(busy),                64'd0);
        check({tag, "_done"},  64'(done),                64'd0);
    endtask

    // Start a fetch of cnt>=1 words from s with ready held high and check every
    // cycle from the first read through the return to idle.
    task automatic stream(input logic [ADDR_W-1:0] s, input int unsigned cnt);
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] ep;
        logic              ev;
        @(negedge clk);
        start      = 1'b1;
        start_addr = s;
        ins_count  = 11'(cnt);
        ins_ready  = 1'b1;
        #1;
        check("st_idle_en", 64'(icache_rd_ctrl_en), 64'd0);
        for (int unsigned j = 1; j <= cnt + 3; j++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            ea = s + 10'(j - 1);
            ep = s + 10'(j - 2);
            ev = (j >= 2) && (j <= cnt + 1);
            check("st_en", 64'(icache_rd_ctrl_en), 64'(j <= cnt));
            check("st_addr", 64'(icache_rd_ctrl_addr), (j <= cnt) ? 64'(ea) : 64'd0);
            check("st_valid", 64'(ins_valid), 64'(ev));
            if (ev) begin
                check("st_pc", 64'(ins_pc), 64'(ep));
                check("st_data", 64'(ins_data), 64'(cache_word(ep)));
            end
            check("st_done", 64'(done), 64'(j == cnt + 2));
            check("st_busy", 64'(busy), 64'(j <= cnt + 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int reads;
        int got;
        bit done_seen;

        rst        = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        ins_ready  = 1'b0;
        start_addr = '0;
        ins_count  = '0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst = 1'b1;

        stream(10'd5, 4);

        // Backpressure: ready low for five cycles; a stray start mid-fetch is ignored.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'd20;
        ins_count  = 11'd6;
        ins_ready  = 1'b0;
        #1;
        reads     = 0;
        got       = 0;
        done_seen = 1'b0;
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            @(negedge clk);
            start      = (c == 3);
            start_addr = (c == 3) ? 10'd300 : 10'd20;
            ins_ready  = (c >= 5);
            #1;
            if (icache_rd_ctrl_en) reads++;
            if (c == 3) begin
                check("bp_en_stall", 64'(icache_rd_ctrl_en), 64'd0);
                check("bp_valid", 64'(ins_valid), 64'd1);
                check("bp_head_pc", 64'(ins_pc), 64'd20);
            end
            if (c == 4) begin
                check("bp_reads_stalled", 64'(reads), 64'd2);
                check("bp_head_hold", 64'(ins_pc), 64'd20);
                check("bp_data_hold", 64'(ins_data), 64'(cache_word(10'd20)));
            end
            if (ins_valid && ins_ready) begin
                check("bp_pc", 64'(ins_pc), 64'(20 + got));
                check("bp_data", 64'(ins_data), 64'(cache_word(10'(20 + got))));
                got++;
            end
            if (done) done_seen = 1'b1;
        end
        check("bp_done_seen", 64'(done_seen), 64'd1);
        check("bp_delivered", 64'(got), 64'd6);
        check("bp_reads", 64'(reads), 64'd6);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("bp_busy_end", 64'(busy), 64'd0);

        stream(10'd1022, 4);

        // Zero count: straight to DONE with no reads.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'd50;
        ins_count  = 11'd0;
        #1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zc_done", 64'(done), 64'd1);
        check("zc_en", 64'(icache_rd_ctrl_en), 64'd0);
        check("zc_valid", 64'(ins_valid), 64'd0);
        check("zc_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check("zc_done_end", 64'(done), 64'd0);
        check("zc_busy_end", 64'(busy), 64'd0);
        check("zc_en_end", 64'(icache_rd_ctrl_en), 64'd0);

        // Flush on the third read cycle, with a competing start.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'd40;
        ins_count  = 11'd10;
        ins_ready  = 1'b1;
        #1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("fl_addr1", 64'(icache_rd_ctrl_addr), 64'd40);
        @(negedge clk);
        #1;
        check("fl_addr2", 64'(icache_rd_ctrl_addr), 64'd41);
        @(negedge clk);
        flush      = 1'b1;
        start      = 1'b1;
        start_addr = 10'd200;
        ins_count  = 11'd3;
        #1;
        check("fl_en_in_flush", 64'(icache_rd_ctrl_en), 64'd0);
        check("fl_done_in_flush", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("fl_valid", 64'(ins_valid), 64'd0);
        check("fl_busy", 64'(busy), 64'd0);
        check("fl_en", 64'(icache_rd_ctrl_en), 64'd0);
        check("fl_done", 64'(done), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("fl_no_done", 64'(done), 64'd0);
            check("fl_no_read", 64'(icache_rd_ctrl_en), 64'd0);
        end
        stream(10'd100, 1);

        // Reset while draining with a full FIFO.
        @(negedge clk);
        start      = 1'b1;
        start_addr = 10'd60;
        ins_count  = 11'd2;
        ins_ready  = 1'b0;
        #1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rd_addr1", 64'(icache_rd_ctrl_addr), 64'd60);
        @(negedge clk);
        #1;
        check("rd_addr2", 64'(icache_rd_ctrl_addr), 64'd61);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rd_drain_valid", 64'(ins_valid), 64'd1);
        check("rd_drain_busy", 64'(busy), 64'd1);
        check("rd_drain_en", 64'(icache_rd_ctrl_en), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rd_after");
        stream(10'd7, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequential instruction fetcher located directly downstream of the instruction cache's control read port, and upstream of the instruction decoder.
- On a start command it walks the PC from start_addr for ins_count instructions. It issues one read per cycle into the cache's combinational read port.
- Fetched words are buffered in a small FIFO and presented to the decoder over a valid/ready handshake. Each word is tagged with its PC.
- Supports flush (abort) and reports busy/done.

Parameters:
- INS_LEN, 54, instruction word width; matches the cache row width.
- ADDR_W, 10, instruction address width (1024-entry cache).
- FIFO_DEPTH, 2, prefetch buffer entries; power of two, ≥2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- start  input  1  one-cycle start pulse; sampled only in IDLE
- start_addr  input  ADDR_W  first PC to fetch
- ins_count  input  ADDR_W+1  number of instructions to fetch (0..1024)
- flush  input  1  abort: empties the FIFO and returns to IDLE
- icache_rd_ctrl_en  output  1  cache read enable
- icache_rd_ctrl_addr  output  ADDR_W  cache read address
- icache_rd_ctrl_data  input  INS_LEN  cache read data; valid in the same cycle as en
- ins_valid  output  1  FIFO head valid
- ins_ready  input  1  decoder accepts the head
- ins_data  output  INS_LEN  instruction at the FIFO head
- ins_pc  output  ADDR_W  PC of ins_data
- busy  output  1  high when state ≠ IDLE
- done  output  1  one-cycle pulse after the last instruction is accepted

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; pc=0; remaining=0; FIFO empty.
  - All outputs 0: icache_rd_ctrl_en, icache_rd_ctrl_addr, ins_valid, ins_data, ins_pc, busy, done.
  - Reset overrides everything, including mid-fetch; no read is issued in a reset cycle.
- States:
  - IDLE:
    - start with ins_count>0 → FETCH; pc←start_addr, remaining←ins_count.
    - start with ins_count==0 → DONE.
    - Without start, remain in IDLE.
  - FETCH:
    - issue = (fifo_cnt<FIFO_DEPTH) || (ins_valid && ins_ready).
    - While issue is high: icache_rd_ctrl_en=1 and icache_rd_ctrl_addr=pc (both combinational from registers). icache_rd_ctrl_data is written into the FIFO tail in the same cycle, tagged with pc. Then pc←pc+1 (wraps 1023→0, modulo 2^ADDR_W) and remaining←remaining−1.
    - When the issue that makes remaining==0 completes → DRAIN.
  - DRAIN: no reads issued; when the FIFO becomes empty after a pop → DONE.
  - DONE: done=1 for exactly one cycle, busy stays 1, → IDLE.
- Handshake:
  - A pop occurs when ins_valid && ins_ready.
  - ins_data, ins_pc and ins_valid come directly from FIFO registers, never from icache_rd_ctrl_data combinationally.
  - A read issued in cycle t makes ins_valid visible in cycle t+1.
  - ins_data and ins_pc are held stable while ins_valid && !ins_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
- Latency:
  - start at cycle t → first read at t+1 → ins_valid at t+2.
  - With ins_ready held high: sustained 1 instruction/cycle, no bubbles.
- Done timing: done asserts in the cycle after the pop of the final instruction. For ins_count==0, done asserts at t+1 with no reads.
- Flush:
  - Highest priority after reset, in any state.
  - FIFO cleared, state→IDLE, no read issued in the flush cycle, done is not pulsed.
  - ins_valid=0 from the next cycle.
  - start in the same cycle as flush is ignored.
- start outside IDLE is ignored.
- icache_rd_ctrl_addr=0 whenever icache_rd_ctrl_en=0.
- Empty FIFO: ins_valid=0 and ins_data/ins_pc=0.

Decomposition:
- Shared package ifu_pkg:
  - typedef fetch_state_e {IDLE, FETCH, DRAIN, DONE}
  - localparams INS_LEN and ADDR_W
  - typedef fetch_entry_t {logic [INS_LEN-1:0] ins; logic [ADDR_W-1:0] pc;}
- One sub-module: fetch_fifo, a parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, clear, full, empty, count, head.
  - Simultaneous push/pop is legal when full.

Test Plan:
- Basic stream: start_addr=5, ins_count=4, ins_ready=1 → reads at addrs 5,6,7,8 in consecutive cycles; ins_pc 5..8 on consecutive cycles starting at t+2; done pulses once at t+6; busy low at t+7.
- Backpressure: ins_count=6, ins_ready=0 for 5 cycles then 1 → exactly 2 reads issued then en=0; head ins_pc=start_addr stable; all 6 delivered in order with no duplicates or drops.
- Wrap-around: start_addr=1022, ins_count=4 → read addrs 1022,1023,0,1; ins_pc matches.
- Zero count: ins_count=0 → icache_rd_ctrl_en never asserted; done at t+1; ins_valid never asserted.
- Flush mid-fetch: ins_count=10, flush at 3rd read cycle → ins_valid=0 next cycle, state IDLE, no done pulse; a new start (addr=100, count=1) then delivers only pc 100.
- Reset mid-operation: rst=0 during DRAIN with FIFO full → next cycle all outputs 0 and busy=0; start is accepted after rst=1.
